// File: rtl/control_sequencer.sv
// ---------------------------------------------------------------------------
// control_sequencer
//
// Multi-cycle sequencer for the control unit. Holds the instruction
// register, the execute sub-state and the latched ALU flags. It also drives
// the 33-bit control word onto the datapath. Each instruction is one fetch
// cycle followed by one or more execute cycles. The execute-cycle control
// words come from external opcode decoders, which are selected from `ir`.
// The sequencer stalls on memory wait states and suppresses side effects
// while stalled. It parks in HALT on an all-zero instruction or when the
// memory bus times out.
//
// Optional feature macro: CONTROL_SEQUENCER_PERF_EN
//   defined   -> retired_count / stall_count are live 32-bit wrapping counters
//   undefined -> both outputs are constant 0 and no counter flops exist
//
// Parameters:
//   MAX_WAIT      consecutive mem_ready-low cycles tolerated (1..255)
// Ports:
//   clock         single clock, rising edge
//   reset         synchronous, active-high
//   data_bus      shared databus; instruction taken from [31:0] in fetch
//   mem_ready     RAM completes the current access this cycle
//   status_in     ALU flags
//   cw_dec        decoder control word for the current (ir, state, status)
//   ir            instruction register
//   state         execute sub-state
//   status        latched flags
//   cw            control word to the datapath (combinational)
//   halted        sequencer is parked
//   bus_error     sticky memory-timeout flag
//   retired_count retired-instruction counter
//   stall_count   wait-cycle counter
// ---------------------------------------------------------------------------
module control_sequencer #(
   parameter int unsigned MAX_WAIT = 15
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [63:0] data_bus,
   input  logic        mem_ready,
   input  logic [4:0]  status_in,
   input  logic [32:0] cw_dec,
   output logic [31:0] ir,
   output logic [1:0]  state,
   output logic [4:0]  status,
   output logic [32:0] cw,
   output logic        halted,
   output logic        bus_error,
   output logic [31:0] retired_count,
   output logic [31:0] stall_count
);

   typedef enum logic [1:0] {
      PH_FETCH = 2'd0,
      PH_EXEC  = 2'd1,
      PH_HALT  = 2'd2
   } phase_t;

   // Control word bit positions
   localparam int RF_W_BIT      = 9;
   localparam int RAM_EN_BIT    = 8;
   localparam int RAM_W_BIT     = 7;
   localparam int PC_FS_LSB     = 4;
   localparam int STATUS_LD_BIT = 2;

   // alu_fs = 11111, rf_sa = rf_sb = 31, everything else 0
   localparam logic [32:0] NOP_WORD   = 33'h0_7DFF_8000;
   localparam logic [7:0]  MAX_WAIT_C = 8'(MAX_WAIT);

   phase_t      phase_q, phase_d;
   logic [31:0] ir_q, ir_d;
   logic [1:0]  state_q, state_d;
   logic [4:0]  status_q, status_d;
   logic        halted_q, halted_d;
   logic        bus_error_q, bus_error_d;
   logic [7:0]  wait_q, wait_d;

   logic        stall;
   logic        wait_cycle;
   logic        retire;
   logic        timeout;

   // Only the low word of the databus carries instructions.
   logic        unused_bus_hi;
   assign unused_bus_hi = ^data_bus[63:32];

   always_comb begin
      stall      = (phase_q == PH_EXEC) &&
                   (cw_dec[RAM_EN_BIT] || cw_dec[RAM_W_BIT]) && !mem_ready;
      wait_cycle = ((phase_q == PH_FETCH) && !mem_ready) || stall;
      retire     = (phase_q == PH_EXEC) && !stall && (cw_dec[1:0] == 2'b00);
      // Counter already at the limit and memory still not ready: the
      // count would exceed MAX_WAIT on this edge.
      timeout    = wait_cycle && (wait_q >= MAX_WAIT_C);

      phase_d     = phase_q;
      ir_d        = ir_q;
      state_d     = state_q;
      status_d    = status_q;
      bus_error_d = bus_error_q;
      wait_d      = wait_cycle ? (wait_q + 8'd1) : 8'd0;

      case (phase_q)
         PH_FETCH: begin
            if (mem_ready) begin
               ir_d    = data_bus[31:0];
               state_d = 2'd0;
               phase_d = (data_bus[31:0] == 32'h0) ? PH_HALT : PH_EXEC;
            end
         end
         PH_EXEC: begin
            if (!stall) begin
               if (cw_dec[STATUS_LD_BIT]) begin
                  status_d = status_in;
               end
               if (cw_dec[1:0] == 2'b00) begin
                  phase_d = PH_FETCH;
                  state_d = 2'd0;
               end else begin
                  state_d = cw_dec[1:0];
               end
            end
         end
         default: begin
            phase_d = PH_HALT;
         end
      endcase

      if (timeout) begin
         bus_error_d = 1'b1;
         phase_d     = PH_HALT;
         wait_d      = wait_q;
      end

      halted_d = (phase_d == PH_HALT);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         phase_q     <= PH_FETCH;
         ir_q        <= 32'h0;
         state_q     <= 2'd0;
         status_q    <= 5'd0;
         halted_q    <= 1'b0;
         bus_error_q <= 1'b0;
         wait_q      <= 8'd0;
      end else begin
         phase_q     <= phase_d;
         ir_q        <= ir_d;
         state_q     <= state_d;
         status_q    <= status_d;
         halted_q    <= halted_d;
         bus_error_q <= bus_error_d;
         wait_q      <= wait_d;
      end
   end

   // Control word to the datapath
   always_comb begin
      cw = NOP_WORD;
      if (!reset) begin
         case (phase_q)
            PH_FETCH: begin
               cw[RAM_EN_BIT] = 1'b1;
               if (mem_ready) begin
                  cw[PC_FS_LSB+1:PC_FS_LSB] = 2'b01;
               end
            end
            PH_EXEC: begin
               cw = cw_dec;
               // A stalled access must not write anything or move the PC.
               if (stall) begin
                  cw[RF_W_BIT]                = 1'b0;
                  cw[RAM_W_BIT]               = 1'b0;
                  cw[PC_FS_LSB+1:PC_FS_LSB]   = 2'b00;
                  cw[STATUS_LD_BIT]           = 1'b0;
               end
            end
            default: begin
               cw = NOP_WORD;
            end
         endcase
      end
   end

   assign ir        = ir_q;
   assign state     = state_q;
   assign status    = status_q;
   assign halted    = halted_q;
   assign bus_error = bus_error_q;

`ifdef CONTROL_SEQUENCER_PERF_EN
   logic [31:0] retired_q, retired_d;
   logic [31:0] stalls_q, stalls_d;

   always_comb begin
      retired_d = retire ? (retired_q + 32'd1) : retired_q;
      stalls_d  = wait_cycle ? (stalls_q + 32'd1) : stalls_q;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         retired_q <= 32'd0;
         stalls_q  <= 32'd0;
      end else begin
         retired_q <= retired_d;
         stalls_q  <= stalls_d;
      end
   end

   assign retired_count = retired_q;
   assign stall_count   = stalls_q;
`else
   logic unused_perf;
   assign unused_perf   = retire;
   assign retired_count = 32'd0;
   assign stall_count   = 32'd0;
`endif

endmodule

// File: tb/tb_control_sequencer.sv
// ---------------------------------------------------------------------------
// tb_control_sequencer
//
// Directed bench for control_sequencer (MAX_WAIT = 4). Each cycle the
// stimulus process drives the inputs and pushes the hand-computed outputs
// expected in that cycle. A monitor pops them on the falling edge and
// compares them against the DUT.
// ---------------------------------------------------------------------------
module tb_control_sequencer;

   logic        clock;
   logic        reset;
   logic [63:0] data_bus;
   logic        mem_ready;
   logic [4:0]  status_in;
   logic [32:0] cw_dec;
   logic [31:0] ir;
   logic [1:0]  state;
   logic [4:0]  status;
   logic [32:0] cw;
   logic        halted;
   logic        bus_error;
   logic [31:0] retired_count;
   logic [31:0] stall_count;

`ifdef CONTROL_SEQUENCER_PERF_EN
   localparam int PERF = 1;
`else
   localparam int PERF = 0;
`endif

   // Hand-computed control words
   localparam logic [32:0] NOP  = 33'h0_7DFF_8000;
   localparam logic [32:0] F    = 33'h0_7DFF_8100;  // fetch, ram_en
   localparam logic [32:0] FR   = 33'h0_7DFF_8110;  // fetch, ram_en, pc+4
   localparam logic [32:0] C1   = 33'h1_7DFF_8210;  // rf_w, pc+4, ns=00
   localparam logic [32:0] C2A  = 33'h1_7DFF_8001;  // ns=01
   localparam logic [32:0] C2B  = 33'h1_7DFF_8006;  // status_ld, ns=10
   localparam logic [32:0] C2C  = 33'h1_7DFF_8610;  // rf_w, pc+4, ns=00
   localparam logic [32:0] CX   = 33'h1_7DFF_8002;  // ns=10
   localparam logic [32:0] CS   = 33'h1_7DFF_8394;  // store: rf_w ram_en ram_w pc+4 status_ld
   localparam logic [32:0] CSST = 33'h1_7DFF_8100;  // CS as seen while stalled

   control_sequencer #(.MAX_WAIT(4)) dut (
      .clock         (clock),
      .reset         (reset),
      .data_bus      (data_bus),
      .mem_ready     (mem_ready),
      .status_in     (status_in),
      .cw_dec        (cw_dec),
      .ir            (ir),
      .state         (state),
      .status        (status),
      .cw            (cw),
      .halted        (halted),
      .bus_error     (bus_error),
      .retired_count (retired_count),
      .stall_count   (stall_count)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic [32:0] cw;
      logic [31:0] ir;
      logic [1:0]  st;
      logic [4:0]  stat;
      logic        h;
      logic        be;
      logic [31:0] ret;
      logic [31:0] stl;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL cycle %0d %s: got %h expected %h", cyc, name, act, req);
      end
   endtask

   // Monitor: compare on the falling edge, away from the active edge
   always @(negedge clock) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         check("cw",            64'(cw),            64'(e.cw));
         check("ir",            64'(ir),            64'(e.ir));
         check("state",         64'(state),         64'(e.st));
         check("status",        64'(status),        64'(e.stat));
         check("halted",        64'(halted),        64'(e.h));
         check("bus_error",     64'(bus_error),     64'(e.be));
         check("retired_count", 64'(retired_count), 64'(e.ret));
         check("stall_count",   64'(stall_count),   64'(e.stl));
         $display("cycle %0d: rst=%b rdy=%b cw=%h ir=%h state=%0d status=%b halted=%b berr=%b ret=%0d stall=%0d",
                  cyc, reset, mem_ready, cw, ir, state, status, halted, bus_error,
                  retired_count, stall_count);
      end
   end

   task automatic step(input bit chk, input logic rst, input logic mr,
                       input logic [63:0] db, input logic [32:0] cwd, input logic [4:0] sin,
                       input logic [32:0] e_cw, input logic [31:0] e_ir, input logic [1:0] e_st,
                       input logic [4:0] e_stat, input logic e_h, input logic e_be,
                       input int e_ret, input int e_stl);
      exp_t e;
      reset     = rst;
      mem_ready = mr;
      data_bus  = db;
      cw_dec    = cwd;
      status_in = sin;
      if (chk) begin
         e.cw   = e_cw;
         e.ir   = e_ir;
         e.st   = e_st;
         e.stat = e_stat;
         e.h    = e_h;
         e.be   = e_be;
         e.ret  = 32'(e_ret * PERF);
         e.stl  = 32'(e_stl * PERF);
         exp_q.push_back(e);
      end
      @(posedge clock);
      #1;
      cyc++;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

   initial begin
      // Reset
      step(0, 1, 1, 64'h0, C1, 5'd0, NOP, 32'h0, 2'd0, 5'd0, 0, 0, 0, 0);
      step(1, 1, 1, 64'h0, C1, 5'd0, NOP, 32'h0, 2'd0, 5'd0, 0, 0, 0, 0);
      // Single-state instruction
      step(1, 0, 1, 64'h9400_0010, C1, 5'd0, FR, 32'h0,         2'd0, 5'd0, 0, 0, 0, 0);
      step(1, 0, 1, 64'h0,         C1, 5'd0, C1, 32'h9400_0010, 2'd0, 5'd0, 0, 0, 0, 0);
      // Multi-state instruction 01, 10, 00 with a status load in state 1
      step(1, 0, 1, 64'h1234_5678, C1,  5'd0,      FR,  32'h9400_0010, 2'd0, 5'd0,      0, 0, 1, 0);
      step(1, 0, 1, 64'h0,         C2A, 5'd0,      C2A, 32'h1234_5678, 2'd0, 5'd0,      0, 0, 1, 0);
      step(1, 0, 1, 64'h0,         C2B, 5'b10110,  C2B, 32'h1234_5678, 2'd1, 5'd0,      0, 0, 1, 0);
      step(1, 0, 1, 64'h0,         C2C, 5'd0,      C2C, 32'h1234_5678, 2'd2, 5'b10110,  0, 0, 1, 0);
      // Store with 3 stall cycles; status_ld during stall must be ignored
      step(1, 0, 1, 64'hABCD_0001, C1, 5'd0,     FR,   32'h1234_5678, 2'd0, 5'b10110, 0, 0, 2, 0);
      step(1, 0, 0, 64'h0,         CS, 5'b00001, CSST, 32'hABCD_0001, 2'd0, 5'b10110, 0, 0, 2, 0);
      step(1, 0, 0, 64'h0,         CS, 5'b00001, CSST, 32'hABCD_0001, 2'd0, 5'b10110, 0, 0, 2, 1);
      step(1, 0, 0, 64'h0,         CS, 5'b00001, CSST, 32'hABCD_0001, 2'd0, 5'b10110, 0, 0, 2, 2);
      step(1, 0, 1, 64'h0,         CS, 5'b00001, CS,   32'hABCD_0001, 2'd0, 5'b10110, 0, 0, 2, 3);
      // Fetch timeout: 5 low-ready cycles with MAX_WAIT = 4
      step(1, 0, 0, 64'h0,  C1, 5'd0, F,   32'hABCD_0001, 2'd0, 5'b00001, 0, 0, 3, 3);
      step(1, 0, 0, 64'h0,  C1, 5'd0, F,   32'hABCD_0001, 2'd0, 5'b00001, 0, 0, 3, 4);
      step(1, 0, 0, 64'h0,  C1, 5'd0, F,   32'hABCD_0001, 2'd0, 5'b00001, 0, 0, 3, 5);
      step(1, 0, 0, 64'h0,  C1, 5'd0, F,   32'hABCD_0001, 2'd0, 5'b00001, 0, 0, 3, 6);
      step(1, 0, 0, 64'h0,  C1, 5'd0, F,   32'hABCD_0001, 2'd0, 5'b00001, 0, 0, 3, 7);
      step(1, 0, 1, 64'h77, C1, 5'd0, NOP, 32'hABCD_0001, 2'd0, 5'b00001, 1, 1, 3, 8);
      step(1, 0, 1, 64'h77, C1, 5'd0, NOP, 32'hABCD_0001, 2'd0, 5'b00001, 1, 1, 3, 8);
      // Reset out of HALT
      step(1, 1, 1, 64'h0,  C1, 5'd0, NOP, 32'hABCD_0001, 2'd0, 5'b00001, 1, 1, 3, 8);
      // Reset dominance mid-EXEC with state = 2
      step(1, 0, 1, 64'h55, C1,  5'd0, FR,  32'h0,  2'd0, 5'd0, 0, 0, 0, 0);
      step(1, 0, 1, 64'h0,  C2A, 5'd0, C2A, 32'h55, 2'd0, 5'd0, 0, 0, 0, 0);
      step(1, 0, 1, 64'h0,  CX,  5'd0, CX,  32'h55, 2'd1, 5'd0, 0, 0, 0, 0);
      step(1, 1, 1, 64'h0,  C1,  5'd0, NOP, 32'h55, 2'd2, 5'd0, 0, 0, 0, 0);
      // Fetch of all-zero instruction halts
      step(1, 0, 0, 64'h0,  C1, 5'd0, F,   32'h0, 2'd0, 5'd0, 0, 0, 0, 0);
      step(1, 0, 1, 64'h0,  C1, 5'd0, FR,  32'h0, 2'd0, 5'd0, 0, 0, 0, 1);
      step(1, 0, 1, 64'h99, C1, 5'd0, NOP, 32'h0, 2'd0, 5'd0, 1, 0, 0, 1);
      step(0, 0, 1, 64'h99, C1, 5'd0, NOP, 32'h0, 2'd0, 5'd0, 1, 0, 0, 1);
      check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
